ifft4_seq: RTL and testbench
============================

// Module: ifft4_seq
// PURPOSE
//  Sequential 4-point radix-2 DIT inverse FFT; the inverse path for the 4-point forward FFT.
//  Accepts 4 complex frequency bins X[0..3] serially, computes x[n] = sum X[k]*W4^(-nk) with one
//  time-shared complex butterfly, and streams 4 time-domain samples x[0..3] out serially.
//  Valid/ready on both sides; sits between the spectral processing stage and the sample sink.
// PARAMETERS
//  DW   8   signed width of each input component (re, im); output components are OW = DW+2
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    reset, synchronous, active-high
//  in_valid   in   1    input bin valid
//  in_ready   out  1    block can accept a bin this cycle
//  in_re      in   DW   signed real part of X[k], k = 0,1,2,3 in arrival order
//  in_im      in   DW   signed imag part of X[k]
//  out_valid  out  1    output sample valid
//  out_ready  in   1    sink accepts sample this cycle
//  out_re     out  OW   signed real part of x[n], n = 0,1,2,3 in output order
//  out_im     out  OW   signed imag part of x[n]
//  out_last   out  1    high with x[3]
//  busy       out  1    high in every state except LOAD
// BEHAVIOUR
//  - One clock (clk); synchronous active-high rst. On rst: state=LOAD, counters 0, in_ready=1,
//    out_valid=0, out_last=0, out_re/out_im=0, busy=0, internal sample registers cleared.
//  - FSM: LOAD -> ST1 -> ST2 -> UNLOAD -> LOAD.
//  - LOAD: in_ready=1; each in_valid&in_ready stores bin at idx (0..3), sign-extended to OW.
//    Transfer of idx 3 -> ST1 next cycle; in_ready=0 from then until back in LOAD.
//  - ST1 (2 cycles, one butterfly each): c0: a0=X0+X2, a1=X0-X2; c1: b0=X1+X3, b1=X1-X3.
//  - ST2 (2 cycles): c0: x0=a0+b0, x2=a0-b0; c1: t=j*b1=(-b1.im, b1.re), x1=a1+t, x3=a1-t.
//  - UNLOAD: out_valid=1, presents x[cnt] cnt=0..3; cnt advances only on out_valid&out_ready;
//    data held stable while out_ready=0. out_last=1 when cnt=3. Transfer of x3 -> LOAD next
//    cycle (in_ready=1 that cycle); no overlap of input and output phases.
//  - Latency: 4th input accept at cycle T -> out_valid=1 at T+5 (ST1 T+1..T+2, ST2 T+3..T+4).
//  - Arithmetic: all adds/subs in OW bits, two's complement; worst case |x| = 4*2^(DW-1) fits
//    exactly in OW, no overflow/saturation. Negation of -2^(DW-1) computed in OW, never DW.
//  - in_valid while in_ready=0 is ignored (bin not consumed, no error). out_ready while
//    out_valid=0 is ignored.
//  - rst mid-frame (any state) aborts the frame: partial inputs and pending outputs discarded,
//    no out_valid after rst deasserts until a new full 4-bin frame is loaded.
// CONFIGURATION
//  IFFT4_SCALE_EN defined: outputs scaled by 1/4 (arithmetic shift right 2, floor rounding)
//    at the UNLOAD mux; ports keep width OW, upper two bits are sign extension.
//  IFFT4_SCALE_EN undefined: outputs unscaled (sum without 1/N), full OW range used.
//  No other behaviour or timing differs between the two builds.
// STRUCTURE
//  Package ifft4_pkg: N=4, state encoding (LOAD, ST1, ST2, UNLOAD), 2-bit index type,
//    OW derivation function/constant.
//  Sub-module ifft4_bfly: combinational complex butterfly, inputs p,q (OW), input rot_j
//    selecting q or j*q; outputs p+q, p-q. Single instance, operands muxed by FSM.
//  Top holds 4-entry complex register file (re/im), FSM, in/out counters.
// TESTING (DW=8; scaled values in [] with IFFT4_SCALE_EN)
//  1. X=(4,0,0,0) -> x=(4,4,4,4) [1,1,1,1], out_last only on 4th, out_valid at T+5.
//  2. X=(0,4,0,0) -> x=(4, 4j, -4, -4j) [1, j, -1, -j]; checks +j twiddle sign.
//  3. X all =(-128,-128) -> x0=(-512,-512), x1..x3=0 [x0=(-128,-128)]; no overflow.
//  4. out_ready toggled 1-0-0-1 pattern: data stable while stalled, 4 samples exactly,
//    in_ready rises the cycle after x3 transfer; in_valid held high meanwhile is not consumed.
//  5. rst asserted after 2 inputs, then in ST2, then in UNLOAD with cnt=2 -> all outputs at
//    reset values next cycle; following clean frame X=(1,1,1,1) -> x=(4,0,0,0) [1,0,0,0].
//  6. 200 random frames with random valid/ready gaps vs. reference model (floor-scaled).

Source files
------------

// File: rtl/ifft4_pkg.sv
// Shared types and constants for the 4-point sequential inverse FFT.
package ifft4_pkg;

  localparam int unsigned N = 4;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_ST1    = 2'd1,
    S_ST2    = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  typedef logic [1:0] idx_t;

  // Output component width: two bits of growth for a 4-term sum.
  function automatic int unsigned ow_of(input int unsigned dw);
    return dw + 32'd2;
  endfunction

  // The in-place butterfly schedule leaves x[n] at the bit-reversed slot.
  function automatic idx_t bitrev(input idx_t i);
    return {i[0], i[1]};
  endfunction

endpackage

// File: rtl/ifft4_bfly.sv
// Combinational complex radix-2 butterfly; optionally rotates q by +j first.
module ifft4_bfly #(
  parameter int unsigned OW = 10
) (
  input  logic signed [OW-1:0] i_p_re,
  input  logic signed [OW-1:0] i_p_im,
  input  logic signed [OW-1:0] i_q_re,
  input  logic signed [OW-1:0] i_q_im,
  input  logic                 i_rot_j,
  output logic signed [OW-1:0] o_sum_re,
  output logic signed [OW-1:0] o_sum_im,
  output logic signed [OW-1:0] o_dif_re,
  output logic signed [OW-1:0] o_dif_im
);

  logic signed [OW-1:0] w_q_re;
  logic signed [OW-1:0] w_q_im;

  // j*q = (-q.im, q.re); negation stays at full OW width
  always_comb begin
    w_q_re   = i_q_re;
    w_q_im   = i_q_im;
    if (i_rot_j) begin
      w_q_re = -i_q_im;
      w_q_im = i_q_re;
    end
    o_sum_re = i_p_re + w_q_re;
    o_sum_im = i_p_im + w_q_im;
    o_dif_re = i_p_re - w_q_re;
    o_dif_im = i_p_im - w_q_im;
  end

endmodule

// File: rtl/ifft4_seq.sv
// Sequential 4-point radix-2 DIT inverse FFT with valid/ready streaming ports.
// Optional build macro: IFFT4_SCALE_EN scales outputs by 1/4 (floor) at the output mux.
module ifft4_seq
  import ifft4_pkg::*;
#(
  parameter  int unsigned DW = 8,
  localparam int unsigned OW = ow_of(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_re,
  output logic [OW-1:0] out_im,
  output logic          out_last,
  output logic          busy
);

  logic signed [OW-1:0] r_re [N];
  logic signed [OW-1:0] r_im [N];
  state_t               r_state;
  idx_t                 r_cnt;

  idx_t                 w_p_idx;
  idx_t                 w_q_idx;
  logic                 w_rot_j;
  idx_t                 w_rd_idx;
  logic signed [OW-1:0] w_sum_re;
  logic signed [OW-1:0] w_sum_im;
  logic signed [OW-1:0] w_dif_re;
  logic signed [OW-1:0] w_dif_im;
  logic signed [OW-1:0] w_rd_re;
  logic signed [OW-1:0] w_rd_im;
  logic signed [OW-1:0] w_out_re;
  logic signed [OW-1:0] w_out_im;

  // Butterfly operand selection: ST1 pairs (0,2),(1,3); ST2 pairs (0,1),(2,3) with +j on the second
  always_comb begin
    w_p_idx = {1'b0, r_cnt[0]};
    w_q_idx = {1'b1, r_cnt[0]};
    w_rot_j = 1'b0;
    if (r_state == S_ST2) begin
      w_p_idx = {r_cnt[0], 1'b0};
      w_q_idx = {r_cnt[0], 1'b1};
      w_rot_j = r_cnt[0];
    end
  end

  ifft4_bfly #(.OW(OW)) u_bfly (
    .i_p_re  (r_re[w_p_idx]),
    .i_p_im  (r_im[w_p_idx]),
    .i_q_re  (r_re[w_q_idx]),
    .i_q_im  (r_im[w_q_idx]),
    .i_rot_j (w_rot_j),
    .o_sum_re(w_sum_re),
    .o_sum_im(w_sum_im),
    .o_dif_re(w_dif_re),
    .o_dif_im(w_dif_im)
  );

  // Output mux: x[0] preloaded on entry to UNLOAD, then x[cnt+1] on each accepted sample
  always_comb begin
    w_rd_idx = (r_state == S_UNLOAD) ? bitrev(r_cnt + 2'd1) : 2'd0;
    w_rd_re  = r_re[w_rd_idx];
    w_rd_im  = r_im[w_rd_idx];
`ifdef IFFT4_SCALE_EN
    w_out_re = w_rd_re >>> 2;
    w_out_im = w_rd_im >>> 2;
`else
    w_out_re = w_rd_re;
    w_out_im = w_rd_im;
`endif
  end

  // Frame FSM, in-place register file updates and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_re[r_cnt] <= {{(OW-DW){in_re[DW-1]}}, in_re};
            r_im[r_cnt] <= {{(OW-DW){in_im[DW-1]}}, in_im};
            r_cnt       <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state  <= S_ST1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        S_ST1, S_ST2: begin
          r_re[w_p_idx] <= w_sum_re;
          r_im[w_p_idx] <= w_sum_im;
          r_re[w_q_idx] <= w_dif_re;
          r_im[w_q_idx] <= w_dif_im;
          r_cnt         <= r_cnt[0] ? 2'd0 : 2'd1;
          if (r_cnt[0]) begin
            if (r_state == S_ST1) begin
              r_state <= S_ST2;
            end else begin
              r_state   <= S_UNLOAD;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_re    <= w_out_re;
              out_im    <= w_out_im;
            end
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (r_cnt == 2'd3) begin
              r_state   <= S_LOAD;
              r_cnt     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              r_cnt    <= r_cnt + 2'd1;
              out_re   <= w_out_re;
              out_im   <= w_out_im;
              out_last <= (r_cnt == 2'd2);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft4_seq.sv
// Self-checking bench for ifft4_seq: vector table, corner-case sequences and random frames.
module tb_ifft4_seq;

  typedef logic signed [15:0] s16_t;
  typedef struct packed {
    s16_t [0:3] xr;
    s16_t [0:3] xi;
    s16_t [0:3] er;
    s16_t [0:3] ei;
  } vec_t;
  typedef struct {
    int re;
    int im;
    int last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_re;
  logic [7:0] in_im;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_re;
  logic [9:0] out_im;
  logic       out_last;
  logic       busy;

  int   n_tot;
  int   n_bad;
  int   rdy_mode;
  exp_t q[$];
  vec_t tab[5];

  logic       pv;
  logic       pr;
  logic [9:0] pre;
  logic [9:0] pim;
  logic       plast;

`ifdef IFFT4_SCALE_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  ifft4_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int expv);
    n_tot++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Reference: x[n] = sum_k X[k] * j^(n*k), optionally floor-scaled by 1/4
  task automatic push_model(input int xr[4], input int xi[4]);
    exp_t e;
    int   yr;
    int   yi;
    for (int n = 0; n < 4; n++) begin
      yr = 0;
      yi = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin yr += xr[k]; yi += xi[k]; end
          1: begin yr -= xi[k]; yi += xr[k]; end
          2: begin yr -= xr[k]; yi -= xi[k]; end
          default: begin yr += xi[k]; yi -= xr[k]; end
        endcase
      end
      e.re   = yr >>> SH;
      e.im   = yi >>> SH;
      e.last = (n == 3) ? 1 : 0;
      q.push_back(e);
    end
  endtask

  task automatic push_tab(input int idx);
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      e.re   = int'(tab[idx].er[n]);
      e.im   = int'(tab[idx].ei[n]);
      e.last = (n == 3) ? 1 : 0;
      q.push_back(e);
    end
  endtask

  task automatic drive_bins(input int xr[4], input int xi[4], input int k0, input bit gaps);
    bit acc;
    int g;
    for (int k = k0; k < 4; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_re    = 8'(xr[k]);
      in_im    = 8'(xi[k]);
      g = 0;
      do begin
        acc = in_ready;
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 100);
      if (!acc) check("in_accept_timeout", int'(in_ready), 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int g;
    g = 0;
    while (!out_valid && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
    check("wait_out_valid", int'(out_valid), 1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"},  int'(out_last),  0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_out_re"},    int'(out_re),    0);
    check({tag, "_out_im"},    int'(out_im),    0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Sink-side scoreboard and hold-while-stalled checker
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_re_held", int'(out_re), int'(pre));
        check("stall_im_held", int'(out_im), int'(pim));
        check("stall_last_held", int'(out_last), int'(plast));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", int'(out_valid), 0);
        end else begin
          e = q.pop_front();
          check("out_re", int'($signed(out_re)), e.re);
          check("out_im", int'($signed(out_im)), e.im);
          check("out_last", int'(out_last), e.last);
        end
      end
      pv    = out_valid;
      pr    = out_ready;
      pre   = out_re;
      pim   = out_im;
      plast = out_last;
    end
  end

  // Sink ready generator: 0 = always ready, 1 = random, 2 = driven by the test sequence
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int    xr[4];
    int    xi[4];
    int    br[4];
    int    bi[4];
    int    xf;
    int    i;
    logic  v;
    logic [3:0] pat;

    n_tot     = 0;
    n_bad     = 0;
    rdy_mode  = 0;
    pv        = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;

    // rows: X (re,im), expected x (re,im) for the selected build
    tab[0].xr = {16'sd4, 16'sd0, 16'sd0, 16'sd0};
    tab[0].xi = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[1].xr = {16'sd0, 16'sd4, 16'sd0, 16'sd0};
    tab[1].xi = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[2].xr = {-16'sd128, -16'sd128, -16'sd128, -16'sd128};
    tab[2].xi = {-16'sd128, -16'sd128, -16'sd128, -16'sd128};
    tab[3].xr = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
    tab[3].xi = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[4].xr = {16'sd0, 16'sd0, 16'sd4, 16'sd0};
    tab[4].xi = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
`ifdef IFFT4_SCALE_EN
    tab[0].er = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
    tab[0].ei = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[1].er = {16'sd1, 16'sd0, -16'sd1, 16'sd0};
    tab[1].ei = {16'sd0, 16'sd1, 16'sd0, -16'sd1};
    tab[2].er = {-16'sd128, 16'sd0, 16'sd0, 16'sd0};
    tab[2].ei = {-16'sd128, 16'sd0, 16'sd0, 16'sd0};
    tab[3].er = {16'sd1, 16'sd0, 16'sd0, 16'sd0};
    tab[3].ei = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[4].er = {16'sd1, -16'sd1, 16'sd1, -16'sd1};
    tab[4].ei = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
`else
    tab[0].er = {16'sd4, 16'sd4, 16'sd4, 16'sd4};
    tab[0].ei = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[1].er = {16'sd4, 16'sd0, -16'sd4, 16'sd0};
    tab[1].ei = {16'sd0, 16'sd4, 16'sd0, -16'sd4};
    tab[2].er = {-16'sd512, 16'sd0, 16'sd0, 16'sd0};
    tab[2].ei = {-16'sd512, 16'sd0, 16'sd0, 16'sd0};
    tab[3].er = {16'sd4, 16'sd0, 16'sd0, 16'sd0};
    tab[3].ei = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tab[4].er = {16'sd4, -16'sd4, 16'sd4, -16'sd4};
    tab[4].ei = {16'sd0, 16'sd0, 16'sd0, 16'sd0};
`endif

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("reset");

    // Impulse frame with latency / handshake-phase checks
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'(tab[0].xr[k]);
      xi[k] = int'(tab[0].xi[k]);
    end
    push_tab(0);
    drive_bins(xr, xi, 0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("latency_out_valid_T+%0d", c), int'(out_valid), (c == 5) ? 1 : 0);
      check($sformatf("latency_busy_T+%0d", c), int'(busy), 1);
      check($sformatf("latency_in_ready_T+%0d", c), int'(in_ready), 0);
    end
    @(posedge clk); #1;
    wait_drain();

    // Table frames
    for (int r = 1; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        xr[k] = int'(tab[r].xr[k]);
        xi[k] = int'(tab[r].xi[k]);
      end
      push_tab(r);
      drive_bins(xr, xi, 0, 1'b0);
      wait_drain();
    end

    // Stalled sink (1-0-0-1) with in_valid held high through the busy phase
    rdy_mode  = 2;
    out_ready = 1'b0;
    xr = '{3, -7, 100, -128};
    xi = '{-5, 12, -99, 127};
    br = '{-77, 5, -7, 9};
    bi = '{66, 1, 2, -3};
    push_model(xr, xi);
    push_model(br, bi);
    drive_bins(xr, xi, 0, 1'b0);
    in_valid = 1'b1;
    in_re    = 8'(br[0]);
    in_im    = 8'(bi[0]);
    wait_out_valid();
    check("stall_in_ready_low", int'(in_ready), 0);
    pat = 4'b1001;
    i   = 0;
    xf  = 0;
    while (xf < 4 && i < 60) begin
      out_ready = pat[i % 4];
      v = out_valid;
      @(posedge clk); #1;
      if (v && out_ready) xf++;
      i++;
    end
    check("stall_transfer_count", xf, 4);
    check("stall_in_ready_after_last", int'(in_ready), 1);
    check("stall_out_valid_after_last", int'(out_valid), 0);
    check("stall_busy_after_last", int'(busy), 0);
    @(posedge clk); #1;
    rdy_mode = 0;
    drive_bins(br, bi, 1, 1'b0);
    wait_drain();

    // Reset after two inputs
    xr = '{50, 60, 70, 80};
    xi = '{-1, -2, -3, -4};
    drive_bins(xr, xi, 2, 1'b0);
    pulse_rst();
    chk_reset("rst_partial");

    // Reset during ST2
    push_model(xr, xi);
    drive_bins(xr, xi, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    pulse_rst();
    q.delete();
    chk_reset("rst_st2");

    // Reset during UNLOAD with two samples already taken
    rdy_mode  = 2;
    out_ready = 1'b1;
    push_model(xr, xi);
    drive_bins(xr, xi, 0, 1'b0);
    wait_out_valid();
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    pulse_rst();
    q.delete();
    chk_reset("rst_unload");
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_out_valid_after_rst", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'(tab[3].xr[k]);
      xi[k] = int'(tab[3].xi[k]);
    end
    push_tab(3);
    drive_bins(xr, xi, 0, 1'b0);
    wait_drain();

    // Random frames with source gaps and random sink backpressure
    rdy_mode = 1;
    for (int f = 0; f < 200; f++) begin
      for (int k = 0; k < 4; k++) begin
        xr[k] = int'($urandom_range(0, 255)) - 128;
        xi[k] = int'($urandom_range(0, 255)) - 128;
      end
      push_model(xr, xi);
      drive_bins(xr, xi, 0, 1'b1);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
